// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane counts.
package lsu_pkg;

    localparam int NUM_BYTE_LANES = 4;
    localparam int NUM_HALF_LANES = 2;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    // state        | meaning
    // ST_IDLE      | accepting requests; word stores and errors finish from here
    // ST_LD_WAIT   | Dmem read data arriving; format and register load result
    // ST_RMW_MERGE | Dmem read data arriving; merge sub-word and write back
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LD_WAIT   = 2'd1;
    localparam logic [1:0] ST_RMW_MERGE = 2'd2;

endpackage

// File: rtl/lsu_byte_lane.sv
// Lane logic shared by the load and read-modify-write paths: extract/extend,
// sub-word merge and alignment check.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] ld_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_merged_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [4:0]  byte_idx;
    logic [4:0]  half_idx;

    // Lane selection, extension, merge and alignment are all pure functions of the inputs.
    always_comb begin
        byte_idx     = {off_i, 3'b000};
        half_idx     = {off_i[1], 4'b0000};
        byte_v       = ld_word_i[byte_idx +: 8];
        half_v       = ld_word_i[half_idx +: 16];
        ld_data_o    = ld_word_i;
        st_merged_o  = ld_word_i;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_B: begin
                ld_data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
                st_merged_o[byte_idx +: 8] = wdata_i[7:0];
            end
            SZ_H: begin
                ld_data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
                st_merged_o[half_idx +: 16] = wdata_i[15:0];
                misaligned_o = off_i[0];
            end
            SZ_W: begin
                st_merged_o  = wdata_i;
                misaligned_o = (off_i != 2'b00);
            end
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit in front of the data memory. Word stores complete in one
// cycle; loads and sub-word stores (read-modify-write) take two.
module lsu_dmem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [31:0]       req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic              resp_err_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_st_data_o,
    output logic              dmem_st_en_o,
    input  logic [DATA_W-1:0] dmem_ld_data_i
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [DATA_W-1:0] wdata_q;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic              idle;
    logic              accept;
    logic              range_err;
    logic              req_err;
    logic [1:0]        lane_size;
    logic [1:0]        lane_off;
    logic [31:0]       lane_ld;
    logic [31:0]       lane_merged;
    logic              lane_misaligned;

    assign idle        = (state_q == ST_IDLE);
    // Ready is withheld during reset so nothing can start while the FSM is held.
    assign req_ready_o = idle && !reset_ni;
    assign accept      = req_valid_i && req_ready_o;
    assign range_err   = |req_addr_i[31:ADDR_W+2];
    assign req_err     = lane_misaligned || range_err;

    // Alignment is judged on the live request; formatting/merge on the captured one.
    assign lane_size = idle ? req_size_i      : size_q;
    assign lane_off  = idle ? req_addr_i[1:0] : addr_q[1:0];

    lsu_byte_lane u_lane (
        .size_i       (lane_size),
        .unsigned_i   (uns_q),
        .off_i        (lane_off),
        .ld_word_i    (dmem_ld_data_i),
        .wdata_i      (wdata_q),
        .ld_data_o    (lane_ld),
        .st_merged_o  (lane_merged),
        .misaligned_o (lane_misaligned)
    );

    // Next-state, response and Dmem port decode.
    always_comb begin
        state_d        = state_q;
        resp_valid_d   = 1'b0;
        resp_err_d     = 1'b0;
        resp_rdata_d   = '0;
        dmem_addr_o    = req_addr_i[ADDR_W+1:2];
        dmem_st_data_o = req_wdata_i;
        dmem_st_en_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we_i && (req_size_i == SZ_W)) begin
                        dmem_st_en_o = 1'b1;
                        resp_valid_d = 1'b1;
                    end else if (req_we_i) begin
                        state_d = ST_RMW_MERGE;
                    end else begin
                        state_d = ST_LD_WAIT;
                    end
                end
            end
            ST_LD_WAIT: begin
                dmem_addr_o  = addr_q[ADDR_W+1:2];
                resp_valid_d = 1'b1;
                resp_rdata_d = lane_ld;
                state_d      = ST_IDLE;
            end
            ST_RMW_MERGE: begin
                dmem_addr_o    = addr_q[ADDR_W+1:2];
                dmem_st_data_o = lane_merged;
                dmem_st_en_o   = 1'b1;
                resp_valid_d   = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Reset must cut the write strobe in the same cycle, abandoning any RMW.
        if (reset_ni) begin
            dmem_st_en_o = 1'b0;
        end
    end

    // State, response registers and request capture.
    always_ff @(posedge clock_i or posedge reset_ni) begin
        if (reset_ni) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            if (accept) begin
                addr_q  <= req_addr_i[ADDR_W+1:0];
                size_q  <= req_size_i;
                uns_q   <= req_unsigned_i;
                wdata_q <= req_wdata_i;
            end
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl with a synchronous Dmem model and a
// response scoreboard that also checks response latency.
module tb_lsu_dmem_ctrl;

    logic        clock_i = 1'b0;
    logic        reset_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_err_o;
    logic [31:0] resp_rdata_o;
    logic [9:0]  dmem_addr_o;
    logic [31:0] dmem_st_data_o;
    logic        dmem_st_en_o;
    logic [31:0] dmem_ld_data_i;

    lsu_dmem_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
        .clock_i        (clock_i),
        .reset_ni       (reset_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_err_o     (resp_err_o),
        .resp_rdata_o   (resp_rdata_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_st_data_o (dmem_st_data_o),
        .dmem_st_en_o   (dmem_st_en_o),
        .dmem_ld_data_i (dmem_ld_data_i)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          wr_cnt = 0;
    logic [9:0]  last_wa;
    logic [31:0] last_wd;
    logic [31:0] mem [0:1023];
    logic [31:0] rd_q = '0;

    assign dmem_ld_data_i = rd_q;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clock_i) cyc = cyc + 1;

    // Dmem: write lands at the edge, read data registered (read-first).
    always @(posedge clock_i) begin
        if (dmem_st_en_o) begin
            mem[dmem_addr_o] <= dmem_st_data_o;
            wr_cnt  = wr_cnt + 1;
            last_wa = dmem_addr_o;
            last_wd = dmem_st_data_o;
        end
        rd_q <= mem[dmem_addr_o];
    end

    // Response monitor: pops the scoreboard on every completion pulse.
    always @(posedge clock_i) begin
        exp_t e;
        #1;
        if (resp_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 64'(resp_valid_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk({e.tag, "_err"},   64'(resp_err_o),   64'(e.err));
                chk({e.tag, "_rdata"}, 64'(resp_rdata_o), 64'(e.rdata));
                chk({e.tag, "_lat"},   64'(cyc),          64'(e.due));
            end
        end
    end

    task automatic req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd, input int lat,
                       output int waits);
        exp_t e;
        @(negedge clock_i);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wd;
        waits = 0;
        while (!req_ready_o && waits < 10) begin
            waits++;
            @(negedge clock_i);
        end
        if (!req_ready_o) begin
            chk({tag, "_ready_timeout"}, 64'(req_ready_o), 64'd1);
        end else begin
            e.tag = tag; e.err = e_err; e.rdata = e_rd; e.due = cyc + lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clock_i);
        req_valid_i = 1'b0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            @(negedge clock_i);
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        reset_ni = 1'b1;
        // Drive a valid word store during reset: it must not reach memory.
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
        req_addr_i = 32'h10; req_wdata_i = 32'h5555_5555;
        repeat (3) @(negedge clock_i);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_resp_err",   64'(resp_err_o),   64'd0);
        chk("rst_resp_rdata", 64'(resp_rdata_o), 64'd0);
        chk("rst_st_en",      64'(dmem_st_en_o), 64'd0);
        chk("rst_ready",      64'(req_ready_o),  64'd0);
        chk("rst_no_write",   64'(wr_cnt),       64'd0);
        req_valid_i = 1'b0;
        reset_ni = 1'b0;
        @(negedge clock_i);
        chk("post_rst_ready", 64'(req_ready_o), 64'd1);

        // Word store then load.
        w0 = wr_cnt;
        req("sw_10", 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1, w);
        drain();
        chk("sw_10_wrcnt", 64'(wr_cnt - w0), 64'd1);
        chk("sw_10_waddr", 64'(last_wa), 64'd4);
        chk("sw_10_wdata", 64'(last_wd), 64'hDEAD_BEEF);
        req("lw_10", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, w);
        drain();

        // Byte RMW and byte loads.
        req("sw_10b", 1'b1, 2'b10, 1'b0, 32'h010, 32'h1122_3344, 1'b0, 32'h0, 1, w);
        drain();
        w0 = wr_cnt;
        req("sb_13", 1'b1, 2'b00, 1'b0, 32'h013, 32'h0000_00A5, 1'b0, 32'h0, 2, w);
        drain();
        chk("sb_13_wrcnt", 64'(wr_cnt - w0), 64'd1);
        chk("sb_13_mem",   64'(mem[4]),      64'hA522_3344);
        req("lb_13",  1'b0, 2'b00, 1'b0, 32'h013, 32'h0, 1'b0, 32'hFFFF_FFA5, 2, w);
        req("lbu_13", 1'b0, 2'b00, 1'b1, 32'h013, 32'h0, 1'b0, 32'h0000_00A5, 2, w);
        req("lb_10",  1'b0, 2'b00, 1'b0, 32'h010, 32'h0, 1'b0, 32'h0000_0044, 2, w);
        drain();

        // Halfword RMW and halfword loads.
        req("sw_20", 1'b1, 2'b10, 1'b0, 32'h020, 32'h0, 1'b0, 32'h0, 1, w);
        req("sh_22", 1'b1, 2'b01, 1'b0, 32'h022, 32'h0000_BEEF, 1'b0, 32'h0, 2, w);
        drain();
        chk("sh_22_mem", 64'(mem[8]), 64'hBEEF_0000);
        req("lh_22",  1'b0, 2'b01, 1'b0, 32'h022, 32'h0, 1'b0, 32'hFFFF_BEEF, 2, w);
        req("lhu_22", 1'b0, 2'b01, 1'b1, 32'h022, 32'h0, 1'b0, 32'h0000_BEEF, 2, w);
        drain();

        // Rejected requests: error at A+1, no write.
        w0 = wr_cnt;
        req("err_lw_11",   1'b0, 2'b10, 1'b0, 32'h011,  32'h0,        1'b1, 32'h0, 1, w);
        req("err_sh_03",   1'b1, 2'b01, 1'b0, 32'h003,  32'h1234,     1'b1, 32'h0, 1, w);
        req("err_sw_1000", 1'b1, 2'b10, 1'b0, 32'h1000, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, w);
        req("err_sz11",    1'b0, 2'b11, 1'b0, 32'h000,  32'h0,        1'b1, 32'h0, 1, w);
        drain();
        chk("err_no_write", 64'(wr_cnt - w0), 64'd0);
        chk("err_mem0",     64'(mem[0]),      64'd0);

        // Back-to-back to the same word without forwarding.
        req("b2b_sw", 1'b1, 2'b10, 1'b0, 32'h030, 32'hAABB_CCDD, 1'b0, 32'h0, 1, w);
        req("b2b_sb", 1'b1, 2'b00, 1'b0, 32'h031, 32'h0000_0011, 1'b0, 32'h0, 2, w);
        chk("b2b_sb_waits", 64'(w), 64'd0);
        req("b2b_lw", 1'b0, 2'b10, 1'b0, 32'h030, 32'h0, 1'b0, 32'hAABB_11DD, 2, w);
        chk("b2b_lw_waits", 64'(w), 64'd1);
        drain();

        // Reset in the middle of an RMW.
        req("pre_sw_40", 1'b1, 2'b10, 1'b0, 32'h040, 32'h1234_5678, 1'b0, 32'h0, 1, w);
        drain();
        req("rst_sb_41", 1'b1, 2'b00, 1'b0, 32'h041, 32'h0000_0099, 1'b0, 32'h0, 2, w);
        @(negedge clock_i);
        req_valid_i = 1'b0;
        #1;
        chk("rmw_st_en_before_rst", 64'(dmem_st_en_o), 64'd1);
        w0 = wr_cnt;
        reset_ni = 1'b1;
        #1;
        chk("rmw_st_en_in_rst", 64'(dmem_st_en_o), 64'd0);
        exp_q.delete();
        repeat (2) begin
            @(negedge clock_i);
            chk("rst_rmw_resp_valid", 64'(resp_valid_o), 64'd0);
        end
        reset_ni = 1'b0;
        @(negedge clock_i);
        chk("rst_rmw_resp_valid_after", 64'(resp_valid_o), 64'd0);
        chk("rst_rmw_no_write", 64'(wr_cnt - w0), 64'd0);
        chk("rst_rmw_mem", 64'(mem[16]), 64'h1234_5678);
        req("lw_40_after_rst", 1'b0, 2'b10, 1'b0, 32'h040, 32'h0, 1'b0, 32'h1234_5678, 2, w);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
- Load/store unit sitting directly upstream of the data memory; the core's memory-stage requests enter here and leave as Dmem word accesses.
- Converts byte/halfword/word requests at byte addresses into Dmem word accesses (10-bit word address, word-wide write enable, registered inputs).
- Sub-word stores are handled by read-modify-write. Load data is lane-extracted and sign/zero-extended.
- Misaligned and out-of-range requests are rejected without touching memory.

Parameters:
- ADDR_W, 10, Dmem word-address width; byte-address range is 0 .. 2^(ADDR_W+2)-1.
- DATA_W, 32, data width; fixed at 32, all lane logic assumes 4 bytes.

Ports:
- clock_i  in  1  clock; all state updates on rising edge
- reset_ni  in  1  reset, asynchronous, active-high (1 = reset)
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  high when the controller accepts a request this cycle
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- resp_valid_o  out  1  one-cycle completion pulse; no backpressure
- resp_err_o  out  1  qualified by resp_valid_o; misaligned, out-of-range or illegal size
- resp_rdata_o  out  32  formatted load data; 0 for stores and errors
- dmem_addr_o  out  ADDR_W  word address to Dmem
- dmem_st_data_o  out  32  word write data to Dmem
- dmem_st_en_o  out  1  word write enable to Dmem
- dmem_ld_data_i  in  32  Dmem read data; valid the cycle after the address is presented

Behaviour:
- Reset (async): state = IDLE; resp_valid_o, resp_err_o and resp_rdata_o = 0. dmem_st_en_o = 0 immediately, since it is combinational from state. Any in-flight RMW is abandoned and memory is unchanged.
- States: IDLE, LD_WAIT, RMW_MERGE.
- req_ready_o = 1 only in IDLE. A request is accepted at cycle A when req_valid_i && req_ready_o.
- Error check at accept:
  - half with addr[0] = 1 → error
  - word with addr[1:0] != 0 → error
  - size 11 → error
  - addr[31:ADDR_W+2] != 0 → error
  - On error: no Dmem write; at A+1 resp_valid_o = 1, resp_err_o = 1, resp_rdata_o = 0; state stays IDLE.
- Dmem address during IDLE: dmem_addr_o = req_addr_i[ADDR_W+1:2]. In other states it comes from the captured request address.
- Word store:
  - At A: dmem_st_en_o = 1 and dmem_st_data_o = req_wdata_i.
  - At A+1: resp_valid_o = 1; state stays IDLE, so a new request may be accepted at A+1.
  - Sustained throughput: 1 per cycle.
- Load:
  - At A: address driven, dmem_st_en_o = 0; state → LD_WAIT.
  - In LD_WAIT: lane = addr[1:0]; extract byte lane[8*off+:8] or half [16*off[1]+:16]; extend per req_unsigned_i; register the result.
  - At A+2: resp_valid_o = 1 with the data; state → IDLE.
- Sub-word store:
  - At A: read address driven, no write; state → RMW_MERGE.
  - In RMW_MERGE: merged = dmem_ld_data_i with the target lane(s) replaced by req_wdata_i[7:0] or req_wdata_i[15:0]. Drive dmem_addr_o = captured address, dmem_st_data_o = merged, dmem_st_en_o = 1 for exactly one cycle.
  - At A+2: resp_valid_o = 1; state → IDLE.
- Ordering: Dmem writes land one cycle after st_en. Any access issued by this block on the cycle after a write therefore reads the post-write word. Back-to-back requests to the same word need no forwarding; this property is required and must be verified.
- dmem_st_en_o is never asserted for a load or an erroring request.
- resp_valid_o is high for exactly one cycle per accepted request.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_B, SZ_H, SZ_W
  - state enum
  - localparams for lane counts
- Sub-module lsu_byte_lane (combinational):
  - load extract/extend
  - store merge
  - misalignment detection
- Shared by the load and RMW paths.

Test Plan:
- Reset, then SW 0xDEADBEEF @0x010 → dmem_st_en_o = 1 for one cycle with dmem_addr_o = 4. Then LW @0x010 → resp_rdata_o = 0xDEADBEEF at A+2, resp_err_o = 0.
- SW 0x11223344 @0x010; SB 0xA5 @0x013 → one write of 0xA5223344. LB @0x013 → 0xFFFFFFA5; LBU @0x013 → 0x000000A5.
- SW 0 @0x020; SH 0xBEEF @0x022 → word 0xBEEF0000. LH @0x022 → 0xFFFFBEEF; LHU @0x022 → 0x0000BEEF.
- LW @0x011, SH @0x003, SW @0x1000, size 11 @0x0 → each gives resp_err_o = 1 at A+1, rdata 0, dmem_st_en_o never high.
- Back-to-back: SW 0xAABBCCDD @0x030 at cycle A, SB 0x11 @0x031 at A+1, LW @0x030 at A+3 → load returns 0xAABB11DD. req_ready_o is low at A+2 only.
- Assert reset_ni during RMW_MERGE of SB → dmem_st_en_o drops in the same cycle, the target word is unchanged, and resp_valid_o stays 0.
